riscv_debug_module_0p11: RTL and testbench

Debug Module implementing the RISC-V External Debug Support 0.11 DMI register map for a single hart. It receives DMI requests from the JTAG DTM (`riscv_jtag_dtm_0p11`) and exposes a debug RAM, halt-notification and debug-interrupt state to the hart through an ICB slave port. It drives the hart's debug interrupt and the non-debug/full reset requests.

---
 rtl/riscv_dm_0p11_pkg.sv | 54 +++++
 rtl/riscv_dm_dram.sv | 39 +++
 rtl/riscv_debug_module_0p11.sv | 165 ++++++++++++++++
 tb/tb_riscv_debug_module_0p11.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dm_0p11_pkg.sv
// Shared types and constants for the 0.11 debug module: DMI op/resp codes,
// DMI and hart-side (ICB) register addresses, dminfo fields, packed DMI
// request/response layouts.
package riscv_dm_0p11_pkg;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_SUCCESS = 2'd0,
    DMI_RESP_FAILED  = 2'd2
  } dmi_resp_e;

  // DMI register addresses
  localparam logic [4:0] DMI_ADDR_DMCONTROL = 5'h10;
  localparam logic [4:0] DMI_ADDR_DMINFO    = 5'h11;

  // Hart-side byte addresses
  localparam logic [11:0] ICB_ADDR_HALTNOT  = 12'h100;
  localparam logic [11:0] ICB_ADDR_CLEARINT = 12'h108;
  localparam logic [11:0] ICB_ADDR_DRAM     = 12'h400;

  // dminfo fields
  localparam int DMINFO_VERSION   = 1;  // [1:0]
  localparam int DMINFO_AUTHTYPE0 = 5;  // single set bit position

  // DMI request: [40:36] addr, [35:2] data, [1:0] op
  typedef struct packed {
    logic [4:0]  addr;
    logic [33:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  // DMI response: [35:2] data, [1:0] resp
  typedef struct packed {
    logic [33:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // dminfo word: [15:10] = ram size - 1, authenticated bit, version 1
  function automatic logic [31:0] dminfo_word(input int words);
    logic [31:0] v;
    v                   = '0;
    v[15:10]            = 6'(words - 1);
    v[DMINFO_AUTHTYPE0] = 1'b1;
    v[1:0]              = 2'(DMINFO_VERSION);
    return v;
  endfunction

endpackage

// File: rtl/riscv_dm_dram.sv
// Debug RAM: DRAM_WORDS x 32 register file, one DMI port and one ICB port.
// Latency: combinational reads, writes land on the rising edge.
// Backpressure: none; both ports always accept. Same-edge writes to one word: DMI wins.
// Ports: clk, rst (async high); dmi_we/dmi_idx/dmi_wdata/dmi_rdata;
//        icb_we/icb_idx/icb_wdata/icb_rdata.
module riscv_dm_dram
  import riscv_dm_0p11_pkg::*;
#(
  parameter int DRAM_WORDS = 8,
  parameter int AW         = $clog2(DRAM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dmi_we,
  input  logic [AW-1:0] dmi_idx,
  input  logic [31:0]   dmi_wdata,
  output logic [31:0]   dmi_rdata,
  input  logic          icb_we,
  input  logic [AW-1:0] icb_idx,
  input  logic [31:0]   icb_wdata,
  output logic [31:0]   icb_rdata
);

  logic [31:0] mem [DRAM_WORDS];

  // DMI write is issued after the ICB write so it takes the word on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DRAM_WORDS; i++) mem[i] <= '0;
    end else begin
      if (icb_we) mem[icb_idx] <= icb_wdata;
      if (dmi_we) mem[dmi_idx] <= dmi_wdata;
    end
  end

  assign dmi_rdata = mem[dmi_idx];
  assign icb_rdata = mem[icb_idx];

endmodule

// File: rtl/riscv_debug_module_0p11.sv
// RISC-V 0.11 debug module for one hart: DMI register map, debug RAM, halt/irq handshake.
// Latency: one cycle from request accept to registered response on both DMI and ICB.
// Backpressure: single-entry per port; request ready = ~rsp_valid | rsp_ready.
// Ports: clk, rst (async high); dtm_req_*/dtm_resp_* DMI from the DTM;
//        i_icb_cmd_*/i_icb_rsp_* hart access; o_dbg_irq, o_ndreset, o_fullreset; test_mode.
// Config: RISCV_DM_RESET_CTRL_EN enables ndreset/fullreset state in dmcontrol[1:0].
module riscv_debug_module_0p11
  import riscv_dm_0p11_pkg::*;
#(
  parameter int DRAM_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dtm_req_valid,
  output logic        dtm_req_ready,
  input  logic [40:0] dtm_req_bits,
  output logic        dtm_resp_valid,
  input  logic        dtm_resp_ready,
  output logic [35:0] dtm_resp_bits,
  input  logic        i_icb_cmd_valid,
  output logic        i_icb_cmd_ready,
  input  logic [11:0] i_icb_cmd_addr,
  input  logic        i_icb_cmd_read,
  input  logic [31:0] i_icb_cmd_wdata,
  output logic        i_icb_rsp_valid,
  input  logic        i_icb_rsp_ready,
  output logic [31:0] i_icb_rsp_rdata,
  output logic        o_dbg_irq,
  output logic        o_ndreset,
  output logic        o_fullreset,
  input  logic        test_mode
);

  localparam int          AW       = $clog2(DRAM_WORDS);
  localparam logic [4:0]  DW_ADDR  = 5'(DRAM_WORDS);
  localparam logic [31:0] DMINFO   = dminfo_word(DRAM_WORDS);

  logic interrupt_q, haltnot_q;
  logic [1:0] dmctl_bits;

  // ---------------- DMI side ----------------
  dmi_req_t  req;
  dmi_op_e   op;
  dmi_resp_t rsp_d;
  logic      dmi_fire, dmi_wr, dmi_ram_hit;
  logic [31:0] dram_dmi_rdata, dmi_rd_lo;

  assign req           = dmi_req_t'(dtm_req_bits);
  assign op            = dmi_op_e'(req.op);
  assign dtm_req_ready = ~dtm_resp_valid | dtm_resp_ready;
  assign dmi_fire      = dtm_req_valid & dtm_req_ready;
  assign dmi_wr        = dmi_fire && (op == DMI_OP_WRITE);
  assign dmi_ram_hit   = (req.addr < DW_ADDR);

  always_comb begin
    dmi_rd_lo = '0;
    if (dmi_ram_hit)                         dmi_rd_lo = dram_dmi_rdata;
    else if (req.addr == DMI_ADDR_DMCONTROL) dmi_rd_lo = {30'b0, dmctl_bits};
    else if (req.addr == DMI_ADDR_DMINFO)    dmi_rd_lo = DMINFO;
  end

  // Response data is the pre-write view; the write lands on the same edge.
  always_comb begin
    rsp_d.data = {interrupt_q, haltnot_q, dmi_rd_lo};
    rsp_d.resp = (op == DMI_OP_RSVD) ? DMI_RESP_FAILED : DMI_RESP_SUCCESS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dtm_resp_valid <= 1'b0;
      dtm_resp_bits  <= '0;
    end else if (dmi_fire) begin
      dtm_resp_valid <= 1'b1;
      dtm_resp_bits  <= rsp_d;
    end else if (dtm_resp_ready) begin
      dtm_resp_valid <= 1'b0;
    end
  end

  // ---------------- ICB side ----------------
  logic          icb_fire, icb_wr, icb_ram_hit, icb_haltnot_set, icb_int_clr;
  logic [AW-1:0] icb_idx;
  logic [31:0]   dram_icb_rdata;

  assign i_icb_cmd_ready = ~i_icb_rsp_valid | i_icb_rsp_ready;
  assign icb_fire        = i_icb_cmd_valid & i_icb_cmd_ready;
  assign icb_wr          = icb_fire & ~i_icb_cmd_read;
  assign icb_idx         = i_icb_cmd_addr[AW+1:2];
  // RAM window is naturally aligned, so matching the upper bits is enough.
  assign icb_ram_hit     = ({i_icb_cmd_addr[11:AW+2], {(AW+2){1'b0}}} == ICB_ADDR_DRAM);
  assign icb_haltnot_set = icb_wr && (i_icb_cmd_addr[11:2] == ICB_ADDR_HALTNOT[11:2]);
  assign icb_int_clr     = icb_wr && (i_icb_cmd_addr[11:2] == ICB_ADDR_CLEARINT[11:2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_icb_rsp_valid <= 1'b0;
      i_icb_rsp_rdata <= '0;
    end else if (icb_fire) begin
      i_icb_rsp_valid <= 1'b1;
      i_icb_rsp_rdata <= (i_icb_cmd_read && icb_ram_hit) ? dram_icb_rdata : 32'h0;
    end else if (i_icb_rsp_ready) begin
      i_icb_rsp_valid <= 1'b0;
    end
  end

  // ---------------- Debug RAM ----------------
  riscv_dm_dram #(.DRAM_WORDS(DRAM_WORDS), .AW(AW)) u_dram (
    .clk       (clk),
    .rst       (rst),
    .dmi_we    (dmi_wr & dmi_ram_hit),
    .dmi_idx   (req.addr[AW-1:0]),
    .dmi_wdata (req.data[31:0]),
    .dmi_rdata (dram_dmi_rdata),
    .icb_we    (icb_wr & icb_ram_hit),
    .icb_idx   (icb_idx),
    .icb_wdata (i_icb_cmd_wdata),
    .icb_rdata (dram_icb_rdata)
  );

  // ---------------- interrupt / haltnot ----------------
  // Hart-side events take precedence over DMI on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interrupt_q <= 1'b0;
      haltnot_q   <= 1'b0;
    end else begin
      if (icb_int_clr)                 interrupt_q <= 1'b0;
      else if (dmi_wr && req.data[33]) interrupt_q <= 1'b1;

      if (icb_haltnot_set)             haltnot_q <= 1'b1;
      else if (dmi_wr && !req.data[32]) haltnot_q <= 1'b0;
    end
  end

  assign o_dbg_irq = interrupt_q;

  // ---------------- reset control ----------------
`ifdef RISCV_DM_RESET_CTRL_EN
  logic ndreset_q, fullreset_q;
  logic unused_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ndreset_q   <= 1'b0;
      fullreset_q <= 1'b0;
    end else if (dmi_wr && (req.addr == DMI_ADDR_DMCONTROL)) begin
      ndreset_q   <= req.data[1];
      fullreset_q <= req.data[0];
    end
  end

  assign dmctl_bits  = {ndreset_q, fullreset_q};
  assign o_ndreset   = ndreset_q & ~test_mode;
  assign o_fullreset = fullreset_q & ~test_mode;
  assign unused_bits = ^i_icb_cmd_addr[1:0];
`else
  logic unused_bits;

  assign dmctl_bits  = 2'b00;
  assign o_ndreset   = 1'b0;
  assign o_fullreset = 1'b0;
  assign unused_bits = ^{i_icb_cmd_addr[1:0], test_mode};
`endif

endmodule

// File: tb/tb_riscv_debug_module_0p11.sv
// Testbench for riscv_debug_module_0p11: vector table of DMI/ICB transactions
// plus hand-written sequences for backpressure, same-edge conflicts and reset.
module tb_riscv_debug_module_0p11;

`ifdef RISCV_DM_RESET_CTRL_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam logic [33:0] DC = RC ? 34'h3 : 34'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        dtm_req_valid, dtm_req_ready;
  logic [40:0] dtm_req_bits;
  logic        dtm_resp_valid, dtm_resp_ready;
  logic [35:0] dtm_resp_bits;
  logic        i_icb_cmd_valid, i_icb_cmd_ready;
  logic [11:0] i_icb_cmd_addr;
  logic        i_icb_cmd_read;
  logic [31:0] i_icb_cmd_wdata;
  logic        i_icb_rsp_valid, i_icb_rsp_ready;
  logic [31:0] i_icb_rsp_rdata;
  logic        o_dbg_irq, o_ndreset, o_fullreset, test_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_debug_module_0p11 #(.DRAM_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_bits(dtm_req_bits),
    .dtm_resp_valid(dtm_resp_valid), .dtm_resp_ready(dtm_resp_ready), .dtm_resp_bits(dtm_resp_bits),
    .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
    .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
    .i_icb_cmd_wdata(i_icb_cmd_wdata),
    .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
    .i_icb_rsp_rdata(i_icb_rsp_rdata),
    .o_dbg_irq(o_dbg_irq), .o_ndreset(o_ndreset), .o_fullreset(o_fullreset),
    .test_mode(test_mode)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic dmi_xfer(input logic [1:0] op, input logic [4:0] addr,
                          input logic [33:0] data, output logic [35:0] rbits);
    int n;
    rbits = '0;
    @(negedge clk);
    dtm_req_valid = 1'b1;
    dtm_req_bits  = {addr, data, op};
    n = 0;
    while (!dtm_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!dtm_req_ready) begin
      check("dmi_req_timeout", dtm_req_ready, 1);
      dtm_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    dtm_req_valid = 1'b0;
    n = 0;
    while (!dtm_resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!dtm_resp_valid) check("dmi_resp_timeout", dtm_resp_valid, 1);
    rbits = dtm_resp_bits;
    @(posedge clk); #1;
  endtask

  task automatic icb_xfer(input logic rd, input logic [11:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    rdata = '0;
    @(negedge clk);
    i_icb_cmd_valid = 1'b1;
    i_icb_cmd_addr  = addr;
    i_icb_cmd_read  = rd;
    i_icb_cmd_wdata = wdata;
    n = 0;
    while (!i_icb_cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!i_icb_cmd_ready) begin
      check("icb_cmd_timeout", i_icb_cmd_ready, 1);
      i_icb_cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_icb_cmd_valid = 1'b0;
    n = 0;
    while (!i_icb_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!i_icb_rsp_valid) check("icb_rsp_timeout", i_icb_rsp_valid, 1);
    rdata = i_icb_rsp_rdata;
    @(posedge clk); #1;
  endtask

  // DMI write and ICB write presented on the same edge.
  task automatic both_write(input logic [4:0] daddr, input logic [33:0] ddata,
                            input logic [11:0] iaddr, input logic [31:0] idata);
    @(negedge clk);
    dtm_req_valid   = 1'b1;
    dtm_req_bits    = {daddr, ddata, 2'd2};
    i_icb_cmd_valid = 1'b1;
    i_icb_cmd_addr  = iaddr;
    i_icb_cmd_read  = 1'b0;
    i_icb_cmd_wdata = idata;
    @(posedge clk); #1;
    dtm_req_valid   = 1'b0;
    i_icb_cmd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          icb;
    logic [1:0]  op;      // ICB: 1 read, 2 write
    logic [11:0] addr;
    logic [33:0] wdata;
    bit          tm;
    bit          chk;
    logic [33:0] exp_data;
    logic [1:0]  exp_resp;
    bit          exp_irq, exp_nd, exp_fr;
  } vec_t;

  function automatic vec_t mk(bit icb, logic [1:0] op, logic [11:0] addr, logic [33:0] wd,
                              bit tm, bit chk, logic [33:0] ed, logic [1:0] er,
                              bit irq, bit nd, bit fr);
    vec_t v;
    v.icb = icb; v.op = op; v.addr = addr; v.wdata = wd; v.tm = tm; v.chk = chk;
    v.exp_data = ed; v.exp_resp = er; v.exp_irq = irq; v.exp_nd = nd; v.exp_fr = fr;
    return v;
  endfunction

  initial begin
    vec_t        vecs [19];
    logic [35:0] rb;
    logic [31:0] rd;
    logic [35:0] held;

    vecs[0]  = mk(0, 1, 12'h011, 34'h0,           0, 1, 34'h1C21,        0, 0, 0,  0);
    vecs[1]  = mk(0, 2, 12'h002, 34'h2_1234_5678, 0, 1, 34'h0,           0, 1, 0,  0);
    vecs[2]  = mk(1, 1, 12'h408, 34'h0,           0, 1, 34'h1234_5678,   0, 1, 0,  0);
    vecs[3]  = mk(1, 2, 12'h108, 34'h0,           0, 0, 34'h0,           0, 0, 0,  0);
    vecs[4]  = mk(1, 2, 12'h100, 34'h0,           0, 0, 34'h0,           0, 0, 0,  0);
    vecs[5]  = mk(0, 1, 12'h000, 34'h0,           0, 1, 34'h1_0000_0000, 0, 0, 0,  0);
    vecs[6]  = mk(0, 2, 12'h000, 34'h0_0000_00AA, 0, 1, 34'h1_0000_0000, 0, 0, 0,  0);
    vecs[7]  = mk(0, 1, 12'h000, 34'h0,           0, 1, 34'hAA,          0, 0, 0,  0);
    vecs[8]  = mk(0, 2, 12'h010, 34'h3,           0, 1, 34'h0,           0, 0, RC, RC);
    vecs[9]  = mk(0, 0, 12'h010, 34'h0,           1, 1, DC,              0, 0, 0,  0);
    vecs[10] = mk(0, 1, 12'h010, 34'h0,           0, 1, DC,              0, 0, RC, RC);
    vecs[11] = mk(0, 3, 12'h002, 34'h2_FFFF_FFFF, 0, 1, 34'h1234_5678,   2, 0, RC, RC);
    vecs[12] = mk(0, 1, 12'h002, 34'h0,           0, 1, 34'h1234_5678,   0, 0, RC, RC);
    vecs[13] = mk(0, 2, 12'h010, 34'h0,           0, 1, DC,              0, 0, 0,  0);
    vecs[14] = mk(1, 1, 12'h7F0, 34'h0,           0, 1, 34'h0,           0, 0, 0,  0);
    vecs[15] = mk(0, 1, 12'h015, 34'h0,           0, 1, 34'h0,           0, 0, 0,  0);
    vecs[16] = mk(1, 2, 12'h41C, 34'hCAFE_F00D,   0, 0, 34'h0,           0, 0, 0,  0);
    vecs[17] = mk(0, 1, 12'h007, 34'h0,           0, 1, 34'hCAFE_F00D,   0, 0, 0,  0);
    vecs[18] = mk(1, 1, 12'h420, 34'h0,           0, 1, 34'h0,           0, 0, 0,  0);

    rst = 1'b1; test_mode = 1'b0;
    dtm_req_valid = 1'b0; dtm_req_bits = '0; dtm_resp_ready = 1'b1;
    i_icb_cmd_valid = 1'b0; i_icb_cmd_addr = '0; i_icb_cmd_read = 1'b0;
    i_icb_cmd_wdata = '0; i_icb_rsp_ready = 1'b1;

    #12;
    check("rst_irq", o_dbg_irq, 0);
    check("rst_ndreset", o_ndreset, 0);
    check("rst_fullreset", o_fullreset, 0);
    check("rst_req_ready", dtm_req_ready, 1);
    check("rst_cmd_ready", i_icb_cmd_ready, 1);
    check("rst_resp_valid", dtm_resp_valid, 0);
    check("rst_rsp_valid", i_icb_rsp_valid, 0);
    check("rst_resp_bits", dtm_resp_bits, 0);
    check("rst_rsp_rdata", i_icb_rsp_rdata, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      test_mode = vecs[i].tm;
      if (vecs[i].icb) begin
        icb_xfer(vecs[i].op == 2'd1, vecs[i].addr, vecs[i].wdata[31:0], rd);
        if (vecs[i].chk) check($sformatf("v%0d_icb_rdata", i), rd, vecs[i].exp_data[31:0]);
      end else begin
        dmi_xfer(vecs[i].op, vecs[i].addr[4:0], vecs[i].wdata, rb);
        if (vecs[i].chk) check($sformatf("v%0d_dmi_data", i), rb[35:2], vecs[i].exp_data);
        check($sformatf("v%0d_dmi_resp", i), rb[1:0], vecs[i].exp_resp);
      end
      check($sformatf("v%0d_irq", i), o_dbg_irq, vecs[i].exp_irq);
      check($sformatf("v%0d_ndreset", i), o_ndreset, vecs[i].exp_nd);
      check($sformatf("v%0d_fullreset", i), o_fullreset, vecs[i].exp_fr);
    end
    test_mode = 1'b0;

    // Response held under backpressure
    held = {2'b00, 32'h1234_5678, 2'b00};
    @(negedge clk);
    dtm_resp_ready = 1'b0;
    dtm_req_valid  = 1'b1;
    dtm_req_bits   = {5'h02, 34'h0, 2'd1};
    @(posedge clk); #1;
    dtm_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_req_ready_%0d", c), dtm_req_ready, 0);
      check($sformatf("bp_resp_valid_%0d", c), dtm_resp_valid, 1);
      check($sformatf("bp_resp_bits_%0d", c), dtm_resp_bits, held);
      @(posedge clk); #1;
    end
    dtm_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_resp_drained", dtm_resp_valid, 0);
    check("bp_req_ready_back", dtm_req_ready, 1);

    // Same-edge RAM writes to word 1: DMI value retained
    both_write(5'h01, 34'h0_1111_1111, 12'h404, 32'h2222_2222);
    dmi_xfer(2'd1, 5'h01, 34'h0, rb);
    check("conflict_ram_dmi", rb[35:2], 34'h1111_1111);
    icb_xfer(1'b1, 12'h404, 32'h0, rd);
    check("conflict_ram_icb", rd, 32'h1111_1111);

    // Same-edge interrupt set (DMI) vs clear (ICB): clear wins
    both_write(5'h15, 34'h2_0000_0000, 12'h108, 32'h0);
    check("conflict_irq", o_dbg_irq, 0);

    // Same-edge haltnot clear (DMI) vs set (ICB): set wins
    both_write(5'h15, 34'h0, 12'h100, 32'h0);
    dmi_xfer(2'd1, 5'h15, 34'h0, rb);
    check("conflict_haltnot", rb[35:2], 34'h1_0000_0000);

    // Reset with a response pending
    dmi_xfer(2'd2, 5'h15, 34'h2_0000_0000, rb);
    check("pre_rst_irq", o_dbg_irq, 1);
    @(negedge clk);
    dtm_resp_ready = 1'b0;
    dtm_req_valid  = 1'b1;
    dtm_req_bits   = {5'h11, 34'h0, 2'd1};
    @(posedge clk); #1;
    dtm_req_valid = 1'b0;
    check("pending_resp_valid", dtm_resp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_resp_valid", dtm_resp_valid, 0);
    check("midrst_resp_bits", dtm_resp_bits, 0);
    check("midrst_irq", o_dbg_irq, 0);
    @(negedge clk);
    rst = 1'b0;
    dtm_resp_ready = 1'b1;
    dmi_xfer(2'd1, 5'h00, 34'h0, rb);
    check("post_rst_ram0", rb[35:2], 34'h0);
    dmi_xfer(2'd1, 5'h11, 34'h0, rb);
    check("post_rst_dminfo", rb[35:2], 34'h1C21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
